// File: rtl/ps2_pkg.sv
// -----------------------------------------------------------------------------
// ps2_pkg
// Shared definitions for the PS/2 host transmit and receive paths:
//   - tx_state_e   : host-to-device transmitter state encoding
//   - PS2_RX_PORT  : PicoBlaze port_id read by the scan-code receive path
//   - PS2_TX_PORT  : PicoBlaze port_id that loads a command byte
//   - CMD_*        : common keyboard command bytes
//   - odd_parity() : PS/2 frame parity bit for a data byte
// -----------------------------------------------------------------------------
package ps2_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      RTS   = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4,
      ACK   = 3'd5
   } tx_state_e;

   localparam logic [7:0] PS2_RX_PORT = 8'h0A;
   localparam logic [7:0] PS2_TX_PORT = 8'h0B;

   localparam logic [7:0] CMD_SET_LED = 8'hED;
   localparam logic [7:0] CMD_RESET   = 8'hFF;
   localparam logic [7:0] CMD_ENABLE  = 8'hF4;

   // Odd parity: the returned bit makes the total count of ones in
   // {parity, data} odd.
   function automatic logic odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_clk_filter.sv
// -----------------------------------------------------------------------------
// ps2_clk_filter
// Conditions the raw PS/2 clock pin: a 2-FF synchroniser followed by a
// glitch filter that only changes its level after FILTER_LEN consecutive
// synchronised samples disagree with the current level. Produces a
// one-cycle pulse when the filtered level goes from 1 to 0.
// Shared by the host transmitter and the scan-code receiver.
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous, active-high
//   ps2c_in  in   raw PS/2 clock pin level
//   fall     out  one-cycle pulse on a filtered 1->0 transition
// -----------------------------------------------------------------------------
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic reset,
   input  logic ps2c_in,
   output logic fall
);

   localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

   logic          sync1_q;
   logic          sync2_q;
   logic          level_q;
   logic          level_d;
   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;
   logic          fall_q;
   logic          fall_d;

   // Filter next-state: count disagreeing samples, flip level on the last one.
   always_comb begin
      level_d = level_q;
      cnt_d   = {CW{1'b0}};
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            cnt_d   = {CW{1'b0}};
         end else begin
            level_d = level_q;
            cnt_d   = cnt_q + CW'(1);
         end
      end else begin
         // Any agreeing sample restarts the run, so short glitches vanish.
         cnt_d = {CW{1'b0}};
      end
      fall_d = level_q & ~level_d;
   end

   // Synchroniser and filter registers; the idle PS/2 clock level is high.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= {CW{1'b0}};
         fall_q  <= 1'b0;
      end else begin
         sync1_q <= ps2c_in;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         fall_q  <= fall_d;
      end
   end

   assign fall = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// -----------------------------------------------------------------------------
// ps2_host_tx
// Host-to-device PS/2 transmitter. A PicoBlaze write of a command byte to
// TX_PORT starts a request-to-send: the clock line is held low for
// RTS_CYCLES, then the start bit, 8 data bits (LSB first), odd parity and
// stop bit are presented on the data line, each advanced by a falling edge
// of the device-generated clock, and the frame ends on the device ack clock.
//
// Ports:
//   clk, reset            system clock, asynchronous active-high reset
//   write_strobe, port_id, out_port
//                         PicoBlaze output port interface
//   ps2c_in, ps2d_in      raw PS/2 clock / data pin levels
//   ps2c_low, ps2d_low    1 = pull the pin low (pin = low ? 0 : Z)
//   tx_idle               1 when idle and a new write would be accepted
//   tx_err                (PS2_TX_ACK_CHECK_EN only) 1 = device did not ack
//   tx_done_tick          one-cycle pulse when the frame completes
//
// Build option: define PS2_TX_ACK_CHECK_EN to add the tx_err output, which
// reports the data level sampled on the ack clock edge.
// -----------------------------------------------------------------------------
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter logic [7:0] TX_PORT    = PS2_TX_PORT,
   parameter int         RTS_CYCLES = 6000,
   parameter int         FILTER_LEN = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       write_strobe,
   input  logic [7:0] port_id,
   input  logic [7:0] out_port,
   input  logic       ps2c_in,
   input  logic       ps2d_in,
   output logic       ps2c_low,
   output logic       ps2d_low,
   output logic       tx_idle,
`ifdef PS2_TX_ACK_CHECK_EN
   output logic       tx_err,
`endif
   output logic       tx_done_tick
);

   localparam int RW = $clog2(RTS_CYCLES + 1);
   localparam logic [RW-1:0] RTS_LAST = RW'(RTS_CYCLES - 1);

   tx_state_e     state_q;
   tx_state_e     state_d;
   logic [RW-1:0] rts_cnt_q;
   logic [RW-1:0] rts_cnt_d;
   logic [3:0]    bit_cnt_q;
   logic [3:0]    bit_cnt_d;
   logic [8:0]    shift_q;
   logic [8:0]    shift_d;
   logic          ps2c_low_q;
   logic          ps2c_low_d;
   logic          ps2d_low_q;
   logic          ps2d_low_d;
   logic          tx_idle_q;
   logic          tx_idle_d;
   logic          tx_done_q;
   logic          tx_done_d;
   logic          ps2d_sync1_q;
   logic          ps2d_sync2_q;

   logic          load;
   logic          c_fall;

   ps2_clk_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .clk     (clk),
      .reset   (reset),
      .ps2c_in (ps2c_in),
      .fall    (c_fall)
   );

   assign load = write_strobe && (port_id == TX_PORT) && (state_q == IDLE);

   // Next-state and datapath logic for the transmit sequence.
   always_comb begin
      state_d   = state_q;
      rts_cnt_d = rts_cnt_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_done_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (load) begin
               state_d   = RTS;
               rts_cnt_d = {RW{1'b0}};
               bit_cnt_d = 4'd0;
               shift_d   = {odd_parity(out_port), out_port};
            end else begin
               state_d = IDLE;
            end
         end
         RTS: begin
            if (rts_cnt_q == RTS_LAST) begin
               state_d   = START;
               rts_cnt_d = {RW{1'b0}};
            end else begin
               rts_cnt_d = rts_cnt_q + RW'(1);
            end
         end
         START: begin
            if (c_fall) begin
               state_d   = DATA;
               bit_cnt_d = 4'd0;
            end else begin
               state_d = START;
            end
         end
         DATA: begin
            // Nine falls cover the 8 data bits and the parity bit.
            if (c_fall) begin
               shift_d   = {1'b0, shift_q[8:1]};
               bit_cnt_d = bit_cnt_q + 4'd1;
               if (bit_cnt_q == 4'd8) begin
                  state_d = STOP;
               end else begin
                  state_d = DATA;
               end
            end else begin
               state_d = DATA;
            end
         end
         STOP: begin
            if (c_fall) begin
               state_d = ACK;
            end else begin
               state_d = STOP;
            end
         end
         ACK: begin
            if (c_fall) begin
               state_d   = IDLE;
               tx_done_d = 1'b1;
            end else begin
               state_d = ACK;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Line drives follow the current state one cycle later; tx_idle tracks
   // the next state so it rises together with tx_done_tick.
   always_comb begin
      ps2c_low_d = (state_q == RTS);
      tx_idle_d  = (state_d == IDLE);
      case (state_q)
         START:   ps2d_low_d = 1'b1;
         DATA:    ps2d_low_d = ~shift_q[0];
         default: ps2d_low_d = 1'b0;
      endcase
   end

   // Transmit FSM, datapath and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= IDLE;
         rts_cnt_q  <= {RW{1'b0}};
         bit_cnt_q  <= 4'd0;
         shift_q    <= 9'd0;
         ps2c_low_q <= 1'b0;
         ps2d_low_q <= 1'b0;
         tx_idle_q  <= 1'b1;
         tx_done_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         rts_cnt_q  <= rts_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         ps2c_low_q <= ps2c_low_d;
         ps2d_low_q <= ps2d_low_d;
         tx_idle_q  <= tx_idle_d;
         tx_done_q  <= tx_done_d;
      end
   end

   // Data-line synchroniser; only the ack check looks at the device data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ps2d_sync1_q <= 1'b1;
         ps2d_sync2_q <= 1'b1;
      end else begin
         ps2d_sync1_q <= ps2d_in;
         ps2d_sync2_q <= ps2d_sync1_q;
      end
   end

`ifdef PS2_TX_ACK_CHECK_EN
   logic tx_err_q;
   logic tx_err_d;

   // A high data line on the ack clock edge means the device did not ack.
   always_comb begin
      if (load) begin
         tx_err_d = 1'b0;
      end else if ((state_q == ACK) && c_fall) begin
         tx_err_d = ps2d_sync2_q;
      end else begin
         tx_err_d = tx_err_q;
      end
   end

   // Ack error flag register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tx_err_q <= 1'b0;
      end else begin
         tx_err_q <= tx_err_d;
      end
   end

   assign tx_err = tx_err_q;
`else
   logic ps2d_unused;
   assign ps2d_unused = ps2d_sync2_q;
`endif

   assign ps2c_low     = ps2c_low_q;
   assign ps2d_low     = ps2d_low_q;
   assign tx_idle      = tx_idle_q;
   assign tx_done_tick = tx_done_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// -----------------------------------------------------------------------------
// tb_ps2_host_tx
// Directed bench for ps2_host_tx. A small device model answers each
// request-to-send by clocking the frame and records the host data drive
// just before every falling clock edge: bit 0 = start slot, bits 1..8 =
// data slots, bit 9 = parity slot, bit 10 = stop slot, bit 11 = ack slot.
// Falls per frame: start, 9 in DATA, stop, ack = 12.
// Honours PS2_TX_ACK_CHECK_EN to exercise tx_err.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int HALF = 40;

   logic       clk = 1'b0;
   logic       reset;
   logic       write_strobe;
   logic [7:0] port_id;
   logic [7:0] out_port;
   logic       dev_clk;
   logic       dev_dat;
   logic       ps2c_in;
   logic       ps2d_in;
   logic       ps2c_low;
   logic       ps2d_low;
   logic       tx_idle;
   logic       tx_done_tick;
`ifdef PS2_TX_ACK_CHECK_EN
   logic       tx_err;
   logic       err_at_done = 1'b0;
`endif

   int         compared   = 0;
   int         mismatched = 0;
   int         done_cnt   = 0;
   logic       idle_at_done = 1'b0;

   always #5 clk = ~clk;

   // Open-collector wiring: either side may pull a line low.
   assign ps2c_in = dev_clk & ~ps2c_low;
   assign ps2d_in = dev_dat & ~ps2d_low;

   ps2_host_tx dut (
      .clk          (clk),
      .reset        (reset),
      .write_strobe (write_strobe),
      .port_id      (port_id),
      .out_port     (out_port),
      .ps2c_in      (ps2c_in),
      .ps2d_in      (ps2d_in),
      .ps2c_low     (ps2c_low),
      .ps2d_low     (ps2d_low),
      .tx_idle      (tx_idle),
`ifdef PS2_TX_ACK_CHECK_EN
      .tx_err       (tx_err),
`endif
      .tx_done_tick (tx_done_tick)
   );

   // Count done cycles and capture companion outputs from the same cycle.
   always @(posedge clk) begin
      if (tx_done_tick === 1'b1) begin
         done_cnt     <= done_cnt + 1;
         idle_at_done <= tx_idle;
`ifdef PS2_TX_ACK_CHECK_EN
         err_at_done  <= tx_err;
`endif
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_write(input logic [7:0] pid, input logic [7:0] dat);
      @(negedge clk);
      write_strobe = 1'b1;
      port_id      = pid;
      out_port     = dat;
      @(negedge clk);
      write_strobe = 1'b0;
      port_id      = 8'h00;
      out_port     = 8'h00;
   endtask

   // Count cycles with ps2c_low held high (bounded).
   task automatic wait_rts(output int len);
      int n;
      n   = 0;
      len = 0;
      while (ps2c_low !== 1'b1 && n < 10) begin
         @(negedge clk);
         n++;
      end
      while (ps2c_low === 1'b1 && len < 7000) begin
         @(negedge clk);
         len++;
      end
   endtask

   // Device model: clock the frame until tx_done_tick or 14 falls.
   task automatic dev_frame(input bit glitch, input bit mid_write, input bit nack,
                            output logic [11:0] seen, output int nfalls);
      int base;
      base   = done_cnt;
      seen   = 12'h000;
      nfalls = 0;
      for (int k = 0; k < 14 && done_cnt == base; k++) begin
         repeat (HALF / 2) @(negedge clk);
         if (glitch && k >= 2 && k <= 8) begin
            dev_clk = 1'b0;
            repeat (3) @(negedge clk);
            dev_clk = 1'b1;
            repeat (12) @(negedge clk);
         end
         if (mid_write && k == 4) begin
            do_write(PS2_TX_PORT, CMD_ENABLE);
            do_write(PS2_RX_PORT, 8'h5A);
         end
         if (k == 11) dev_dat = nack;
         if (k < 12) seen[k] = ps2d_low;
         repeat (HALF / 2) @(negedge clk);
         dev_clk = 1'b0;
         nfalls++;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
         dev_dat = 1'b1;
      end
   endtask

   initial begin
      logic [11:0] seen;
      int          nf;
      int          len;
      int          d0;

      reset        = 1'b1;
      dev_clk      = 1'b1;
      dev_dat      = 1'b0;
      dev_dat      = 1'b1;
      write_strobe = 1'b0;
      port_id      = 8'h00;
      out_port     = 8'h00;
      repeat (3) @(negedge clk);
      chk("rst_ps2c_low", ps2c_low, 1'b0);
      chk("rst_ps2d_low", ps2d_low, 1'b0);
      chk("rst_tx_idle", tx_idle, 1'b1);
      chk("rst_done", tx_done_tick, 1'b0);
`ifdef PS2_TX_ACK_CHECK_EN
      chk("rst_tx_err", tx_err, 1'b0);
`endif
      reset = 1'b0;
      repeat (20) @(negedge clk);

      // Write to the receive port: no frame starts.
      do_write(PS2_RX_PORT, CMD_SET_LED);
      repeat (20) @(negedge clk);
      chk("rx_port_no_rts", ps2c_low, 1'b0);
      chk("rx_port_idle", tx_idle, 1'b1);

      // Frame 1: 0xED.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, CMD_SET_LED);
      chk("busy_after_load", tx_idle, 1'b0);
      wait_rts(len);
      chk("rts_len_ed", len, 6000);
      dev_frame(1'b0, 1'b0, 1'b0, seen, nf);
      chk("bits_ed", seen, 12'h025);
      chk("falls_ed", nf, 12);
      repeat (5) @(negedge clk);
      chk("done_once_ed", done_cnt - d0, 1);
      chk("idle_with_done_ed", idle_at_done, 1'b1);
      chk("idle_after_ed", tx_idle, 1'b1);
      chk("lines_released_ed", {ps2c_low, ps2d_low}, 2'b00);

      // Frame 2: 0x00 (parity slot released); device does not ack.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, 8'h00);
      wait_rts(len);
      dev_frame(1'b0, 1'b0, 1'b1, seen, nf);
      chk("bits_00", seen, 12'h1FF);
      chk("parity_slot_00", seen[9], 1'b0);
      repeat (5) @(negedge clk);
      chk("done_once_00", done_cnt - d0, 1);
`ifdef PS2_TX_ACK_CHECK_EN
      chk("nack_err_at_done", err_at_done, 1'b1);
      chk("nack_err_held", tx_err, 1'b1);
`endif

      // Frame 3: 0x01 (parity slot pulled low), with ignored writes mid-frame.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, 8'h01);
`ifdef PS2_TX_ACK_CHECK_EN
      chk("load_clears_err", tx_err, 1'b0);
`endif
      wait_rts(len);
      dev_frame(1'b0, 1'b1, 1'b0, seen, nf);
      chk("bits_01", seen, 12'h3FD);
      chk("parity_slot_01", seen[9], 1'b1);
      repeat (200) @(negedge clk);
      chk("no_second_frame", ps2c_low, 1'b0);
      chk("idle_after_01", tx_idle, 1'b1);
      chk("done_once_01", done_cnt - d0, 1);
`ifdef PS2_TX_ACK_CHECK_EN
      chk("ack_err_clear", err_at_done, 1'b0);
`endif

      // Frame 4: 0xED with short glitches on the clock line.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, CMD_SET_LED);
      wait_rts(len);
      dev_frame(1'b1, 1'b0, 1'b0, seen, nf);
      chk("bits_glitch", seen, 12'h025);
      chk("falls_glitch", nf, 12);
      repeat (5) @(negedge clk);
      chk("done_once_glitch", done_cnt - d0, 1);

      // Reset in the middle of a 0x00 frame.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, 8'h00);
      wait_rts(len);
      for (int p = 0; p < 3; p++) begin
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b0;
         repeat (HALF) @(negedge clk);
         dev_clk = 1'b1;
      end
      repeat (20) @(negedge clk);
      chk("data_drive_before_reset", ps2d_low, 1'b1);
      reset = 1'b1;
      #1;
      chk("mid_rst_ps2c_low", ps2c_low, 1'b0);
      chk("mid_rst_ps2d_low", ps2d_low, 1'b0);
      chk("mid_rst_idle", tx_idle, 1'b1);
      repeat (3) @(negedge clk);
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("no_done_on_reset", done_cnt - d0, 0);

      // Frame 5: 0xFF after reset.
      d0 = done_cnt;
      do_write(PS2_TX_PORT, CMD_RESET);
      wait_rts(len);
      chk("rts_len_ff", len, 6000);
      dev_frame(1'b0, 1'b0, 1'b0, seen, nf);
      chk("bits_ff", seen, 12'h001);
      chk("falls_ff", nf, 12);
      repeat (5) @(negedge clk);
      chk("done_once_ff", done_cnt - d0, 1);
      chk("idle_after_ff", tx_idle, 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
